// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the memory-stage access controller.
//   accessSize_t  : load/store size encoding as presented by the MEM stage
//   ctrlState_t   : controller FSM state encoding
//   timeoutCntWidth(): width of the per-beat timeout counter, $clog2(timeout + 1)
//   laneMask()    : unshifted byte-enable mask for a size
//   accessBytes() : number of bytes touched by a size
// Optional feature macro used by the importing RTL: MISALIGN_SPLIT_EN.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11   // decoded exactly like SizeWord
    } accessSize_t;

    typedef enum logic [2:0] {
        StIdle,
        StBeatLo,
        StBeatHi,
        StDone,
        StErr
    } ctrlState_t;

    localparam int unsigned TimeoutCyclesDefault = 255;

    function automatic int unsigned timeoutCntWidth(input int unsigned timeoutCycles);
        return $clog2(timeoutCycles + 1);
    endfunction

    function automatic logic [3:0] laneMask(input accessSize_t size);
        case (size)
            SizeByte: return 4'b0001;
            SizeHalf: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] accessBytes(input accessSize_t size);
        case (size)
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational sign/zero extension of a lane-aligned load value.
//   dataIn   : load data already shifted so the addressed byte sits in bits [7:0]
//   size     : access size (byte, half, word; illegal treated as word)
//   isSigned : 1 replicates the top bit of the loaded quantity, 0 zero-fills
//   dataOut  : 32-bit writeback value
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] dataIn,
    input  accessSize_t size,
    input  logic        isSigned,
    output logic [31:0] dataOut
);

    always_comb begin
        dataOut = dataIn;
        case (size)
            SizeByte: dataOut = {{24{isSigned & dataIn[7]}}, dataIn[7:0]};
            SizeHalf: dataOut = {{16{isSigned & dataIn[15]}}, dataIn[15:0]};
            default:  dataOut = dataIn;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a single-port data-memory handshake,
// stalls the pipeline while an access is outstanding and produces the extended load result.
//   Parameter TIMEOUT_CYCLES : wait cycles tolerated per beat before a bus error
//   Pipeline side : req_valid/req_write/req_size/req_signed/req_addr/req_wdata/req_rd in,
//                   stall, wb_valid/wb_data/wb_rd, misalign_err, bus_err out
//   Memory side   : mem_req/mem_we/mem_addr/mem_wdata/mem_be out, mem_ready/mem_rdata in
// Optional feature: define MISALIGN_SPLIT_EN to run word-crossing accesses as two beats
// instead of raising misalign_err.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned     CntW   = timeoutCntWidth(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    ctrlState_t      stateQ;
    logic [CntW-1:0] cntQ;
    logic [1:0]      offQ;
    accessSize_t     sizeQ;
    logic            signedQ;
    logic            weQ;
    logic [4:0]      rdQ;

    logic            memReqQ;
    logic            memWeQ;
    logic [31:0]     memAddrQ;
    logic [31:0]     memWdataQ;
    logic [3:0]      memBeQ;
    logic            wbValidQ;
    logic [31:0]     wbDataQ;
    logic [4:0]      wbRdQ;
    logic            misalignErrQ;
    logic            busErrQ;

    accessSize_t     reqSize;
    logic [1:0]      reqOff;
    logic            reqMisaligned;
    logic [3:0]      beLoIn;
    logic [31:0]     wdLoIn;
    logic [31:0]     shiftedData;
    logic [31:0]     extendedData;

    assign reqSize = accessSize_t'(req_size);
    assign reqOff  = req_addr[1:0];

`ifdef MISALIGN_SPLIT_EN
    logic            splitQ;
    logic [3:0]      beHiQ;
    logic [31:0]     wdHiQ;
    logic [31:0]     loDataQ;
    logic            reqSplit;
    logic [7:0]      beWide;
    logic [63:0]     wdWide;

    // Shift into a two-word window; the upper half feeds the second beat.
    always_comb begin
        beWide = {4'b0000, laneMask(reqSize)} << reqOff;
        wdWide = {32'h0, req_wdata} << {reqOff, 3'b000};
    end

    assign beLoIn        = beWide[3:0];
    assign wdLoIn        = wdWide[31:0];
    assign reqSplit      = ({1'b0, reqOff} + accessBytes(reqSize)) > 3'd4;
    assign reqMisaligned = 1'b0;

    always_comb begin
        shiftedData = mem_rdata >> {offQ, 3'b000};
        if (stateQ == StBeatHi) begin
            shiftedData = 32'({mem_rdata, loDataQ} >> {offQ, 3'b000});
        end
    end
`else
    // Natural alignment guarantees the shifted mask/data never leave the word.
    assign beLoIn = laneMask(reqSize) << reqOff;
    assign wdLoIn = req_wdata << {reqOff, 3'b000};

    always_comb begin
        case (reqSize)
            SizeByte: reqMisaligned = 1'b0;
            SizeHalf: reqMisaligned = req_addr[0];
            default:  reqMisaligned = (reqOff != 2'b00);
        endcase
    end

    assign shiftedData = mem_rdata >> {offQ, 3'b000};
`endif

    load_extend uLoadExtend (
        .dataIn   (shiftedData),
        .size     (sizeQ),
        .isSigned (signedQ),
        .dataOut  (extendedData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= StIdle;
            cntQ         <= '0;
            offQ         <= 2'b00;
            sizeQ        <= SizeByte;
            signedQ      <= 1'b0;
            weQ          <= 1'b0;
            rdQ          <= 5'd0;
            memReqQ      <= 1'b0;
            memWeQ       <= 1'b0;
            memAddrQ     <= 32'h0;
            memWdataQ    <= 32'h0;
            memBeQ       <= 4'h0;
            wbValidQ     <= 1'b0;
            wbDataQ      <= 32'h0;
            wbRdQ        <= 5'd0;
            misalignErrQ <= 1'b0;
            busErrQ      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            splitQ       <= 1'b0;
            beHiQ        <= 4'h0;
            wdHiQ        <= 32'h0;
            loDataQ      <= 32'h0;
`endif
        end else begin
            // Completion flags are single-cycle pulses.
            wbValidQ     <= 1'b0;
            misalignErrQ <= 1'b0;
            busErrQ      <= 1'b0;

            case (stateQ)
                StIdle: begin
                    if (req_valid) begin
                        offQ    <= reqOff;
                        sizeQ   <= reqSize;
                        signedQ <= req_signed;
                        weQ     <= req_write;
                        rdQ     <= req_rd;
                        if (reqMisaligned) begin
                            stateQ       <= StErr;
                            misalignErrQ <= 1'b1;
                        end else begin
                            stateQ    <= StBeatLo;
                            cntQ      <= '0;
                            memReqQ   <= 1'b1;
                            memWeQ    <= req_write;
                            memAddrQ  <= {req_addr[31:2], 2'b00};
                            memBeQ    <= beLoIn;
                            memWdataQ <= wdLoIn;
`ifdef MISALIGN_SPLIT_EN
                            splitQ    <= reqSplit;
                            beHiQ     <= beWide[7:4];
                            wdHiQ     <= wdWide[63:32];
`endif
                        end
                    end
                end

                StBeatLo: begin
                    if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
                        if (splitQ) begin
                            stateQ    <= StBeatHi;
                            cntQ      <= '0;
                            loDataQ   <= mem_rdata;
                            memAddrQ  <= memAddrQ + 32'd4;
                            memBeQ    <= beHiQ;
                            memWdataQ <= wdHiQ;
                        end else begin
                            stateQ   <= StDone;
                            memReqQ  <= 1'b0;
                            wbValidQ <= ~weQ;
                            if (!weQ) begin
                                wbDataQ <= extendedData;
                                wbRdQ   <= rdQ;
                            end
                        end
`else
                        stateQ   <= StDone;
                        memReqQ  <= 1'b0;
                        wbValidQ <= ~weQ;
                        if (!weQ) begin
                            wbDataQ <= extendedData;
                            wbRdQ   <= rdQ;
                        end
`endif
                    end else if (cntQ == CntMax) begin
                        stateQ  <= StErr;
                        memReqQ <= 1'b0;
                        busErrQ <= 1'b1;
                    end else begin
                        cntQ <= cntQ + 1'b1;
                    end
                end

`ifdef MISALIGN_SPLIT_EN
                StBeatHi: begin
                    if (mem_ready) begin
                        stateQ   <= StDone;
                        memReqQ  <= 1'b0;
                        wbValidQ <= ~weQ;
                        if (!weQ) begin
                            wbDataQ <= extendedData;
                            wbRdQ   <= rdQ;
                        end
                    end else if (cntQ == CntMax) begin
                        stateQ  <= StErr;
                        memReqQ <= 1'b0;
                        busErrQ <= 1'b1;
                    end else begin
                        cntQ <= cntQ + 1'b1;
                    end
                end
`endif

                StDone:  stateQ <= StIdle;
                StErr:   stateQ <= StIdle;
                default: stateQ <= StIdle;
            endcase
        end
    end

    // The stage advances on the DONE/ERR edge, so req_valid is not looked at there.
    assign stall = rst_n & ((stateQ == StBeatLo) || (stateQ == StBeatHi) ||
                            ((stateQ == StIdle) && req_valid));

    assign wb_valid     = wbValidQ;
    assign wb_data      = wbDataQ;
    assign wb_rd        = wbRdQ;
    assign misalign_err = misalignErrQ;
    assign bus_err      = busErrQ;
    assign mem_req      = memReqQ;
    assign mem_we       = memWeQ;
    assign mem_addr     = memAddrQ;
    assign mem_wdata    = memWdataQ;
    assign mem_be       = memBeQ;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the pipelined processor. Sequences every load/store from the MEM stage onto a single-port data-memory handshake, stalls the pipeline while the access is outstanding, and builds the writeback value. That value is lane-extracted, then sign- or zero-extended for byte and half-word loads, with a bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ready per beat before a bus error.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load/store.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- req_signed  in  1  1 = sign-extend the load, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- req_rd  in  5  load destination register.
- stall  out  1  freeze IF..MEM.
- wb_valid  out  1  one-cycle pulse; wb_data/wb_rd valid (loads only).
- wb_data  out  32  extended load result.
- wb_rd  out  5  destination register.
- misalign_err  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse on timeout.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address, bits [1:0] = 0.
- mem_wdata  out  32  lane-positioned store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  accept/complete strobe.
- mem_rdata  in  32  read data, valid with mem_ready.

## Operation
- States:
  - IDLE: wait for a request.
  - BEAT_LO: first or only beat.
  - BEAT_HI: second beat of a split access.
  - DONE: completion.
  - ERR: error completion.
- stall is combinational: 1 in BEAT_LO/BEAT_HI, and in IDLE when req_valid = 1; 0 otherwise. req_valid is ignored in DONE/ERR because the stage advances on that edge.
- IDLE with req_valid:
  - Access is legal: latch addr, size, signed, wdata and rd, then go to BEAT_LO.
  - Access is misaligned and the macro is absent: go to ERR. misalign_err pulses and no memory access occurs.
- BEAT_LO/BEAT_HI drive mem_req = 1.
  - On mem_ready, capture mem_rdata and go to BEAT_HI (split) or DONE.
- Byte lane offset o = addr[1:0].
  - mem_be = size mask << o.
  - mem_wdata = wdata << 8*o.
- Load result = rdata >> 8*o. The result is then extended by the load_extend sub-module:
  - Byte: bit 7 replicated when signed, else zero fill.
  - Half: bit 15 replicated when signed, else zero fill.
  - Word: passed through unchanged.
- DONE: wb_valid = 1 for loads only, then go to IDLE. Stores complete silently.
- ERR: one cycle, wb_valid = 0, then go to IDLE.
- Timeout: a per-beat counter clears on beat entry and increments each cycle without mem_ready. When the counter equals TIMEOUT_CYCLES, the beat is abandoned: bus_err pulses in ERR and no writeback occurs. mem_ready in the same cycle wins over timeout.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0.
  - All outputs 0, including stall (forced 0 while rst_n = 0), mem_req, wb_data and wb_rd.
- Reset mid-access aborts the access; mem_req drops without waiting for mem_ready.
- Aligned access with zero-wait memory:
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: BEAT_LO, mem_req = 1 with mem_ready.
  - Cycle 2: DONE, wb_valid = 1, stall = 0.
  - Total: 2 stall cycles.
- Each memory wait cycle adds one stall cycle. A split access adds one beat.
- Memory-side outputs are stable for the whole beat.

## Configuration
- MISALIGN_SPLIT_EN defined:
  - An access whose bytes fit in one word (o + bytes ≤ 4) runs as one beat.
  - A word-crossing access runs two beats. BEAT_LO uses addr & ~3 with the low part of the shifted mask/data. BEAT_HI uses (addr & ~3) + 4 with the high part.
  - Load result = {hi_rdata, lo_rdata} >> 8*o, low 32 bits, then extended.
  - misalign_err never pulses.
- MISALIGN_SPLIT_EN absent:
  - Natural alignment is required: half needs addr[0] = 0, word needs addr[1:0] = 0.
  - Any violation goes to ERR with misalign_err.
  - The BEAT_HI state and the hi-data register are not built.

## Structure
- Package mem_ctrl_pkg holds:
  - the access-size enum;
  - the FSM state enum;
  - the timeout counter width, derived via $clog2(TIMEOUT_CYCLES+1).
- Sub-module load_extend (combinational): inputs are the shifted data, size and signed; output is the 32-bit result.

## Test plan
- Aligned signed half load, addr 0x102, rdata 0x8001_0000, mem_ready immediate -> wb_data 0xFFFF_8001, wb_rd echoed, stall high exactly 2 cycles.
- Unsigned byte load, addr 0x203, rdata 0x80xx_xxxx -> wb_data 0x0000_0080; signed -> 0xFFFF_FF80.
- Half store 0x0000_ABCD at addr 0x0E -> mem_addr 0x0C, mem_be 1100, mem_wdata 0xABCD_0000, no wb_valid.
- Word load at 0x101:
  - Macro off -> misalign_err pulse, mem_req never asserted.
  - Macro on, rdata 0x4433_2211 then 0x8877_6655 -> two beats at 0x100/0x104, wb_data 0x5544_3322.
- mem_ready withheld, TIMEOUT_CYCLES = 4 -> bus_err pulse after 4 wait cycles, no wb_valid, back to IDLE; mem_ready on the 4th wait cycle -> normal completion, no bus_err.
- rst_n low during BEAT_LO wait -> mem_req and stall drop immediately; after release, the next request completes normally.
